// File: rtl/fir_coeff_pkg.sv
// Shared constants and types for the SPI-programmed FIR coefficient bank.
package fir_coeff_pkg;

   localparam int NUM_TAPS_DEF = 32;
   localparam int COEF_W_DEF   = 16;

   localparam logic [7:0] ADDR_CTRL        = 8'h20;
   localparam logic [7:0] ADDR_STATUS      = 8'h21;
   localparam logic [7:0] ADDR_ACTIVE_BASE = 8'h80;

   localparam int CTRL_COMMIT_BIT  = 0;
   localparam int CTRL_CLR_ERR_BIT = 1;

   localparam int STATUS_PENDING_BIT = 0;
   localparam int STATUS_ERR_BIT     = 1;
   localparam int STATUS_COUNT_LSB   = 8;

   typedef logic [COEF_W_DEF-1:0] coef_t;

endpackage

// File: rtl/fir_coeff_bank_if.sv
// SPI register bus, sample boundary and tap port of the coefficient bank.
interface fir_coeff_bank_if
   import fir_coeff_pkg::*;
#(
   parameter int COEF_W = COEF_W_DEF
);
   logic              spi_load;
   logic [7:0]        spi_register_address;
   logic [COEF_W-1:0] spi_register_value;
   logic [7:0]        spi_read_address;
   logic [COEF_W-1:0] spi_read_value;
   logic              sample_tick;
   logic [4:0]        tap_index;
   logic [COEF_W-1:0] tap_coef;
   logic              commit_pending;
   logic              err_addr;

   modport master (
      output spi_load, spi_register_address, spi_register_value, spi_read_address,
      output sample_tick, tap_index,
      input  spi_read_value, tap_coef, commit_pending, err_addr
   );

   modport slave (
      input  spi_load, spi_register_address, spi_register_value, spi_read_address,
      input  sample_tick, tap_index,
      output spi_read_value, tap_coef, commit_pending, err_addr
   );
endinterface

// File: rtl/pulse_sync.sv
// Multi-flop synchroniser for an asynchronous strobe, followed by a rising-edge
// detector producing a single-cycle pulse in the destination clock domain.
module pulse_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clk,
   input  logic Reset,
   input  logic async_i,
   output logic pulse_o
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q;

   always_comb sync_d = {sync_q[SYNC_STAGES-2:0], async_i};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/fir_coeff_bank.sv
// Shadow/active FIR coefficient bank written over SPI; the whole shadow bank is
// copied to the active bank on the first sample boundary after a commit request.
module fir_coeff_bank
   import fir_coeff_pkg::*;
#(
   parameter int NUM_TAPS    = NUM_TAPS_DEF,
   parameter int COEF_W      = COEF_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input logic            Clk,
   input logic            Reset,
   fir_coeff_bank_if.slave bus
);
   logic              wr_strobe;
   logic [COEF_W-1:0] shadow_q [NUM_TAPS];
   logic [COEF_W-1:0] shadow_d [NUM_TAPS];
   logic [COEF_W-1:0] active_q [NUM_TAPS];
   logic [COEF_W-1:0] active_d [NUM_TAPS];
   logic              pending_q, pending_d;
   logic              err_q, err_d;
   logic [7:0]        count_q, count_d;
   logic [COEF_W-1:0] rd_q, rd_d;
   logic [COEF_W-1:0] tap_q, tap_d;
   logic [COEF_W-1:0] status;
   logic              commit_now;
   logic [4:0]        wr_idx;
   logic [4:0]        rd_idx;

   pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
      .Clk     (Clk),
      .Reset   (Reset),
      .async_i (bus.spi_load),
      .pulse_o (wr_strobe)
   );

   assign wr_idx = bus.spi_register_address[4:0];
   assign rd_idx = bus.spi_read_address[4:0];

   // Copy reads shadow_q, so a same-cycle shadow write lands only in shadow.
   always_comb begin
      shadow_d   = shadow_q;
      active_d   = active_q;
      pending_d  = pending_q;
      err_d      = err_q;
      count_d    = count_q;
      commit_now = bus.sample_tick && pending_q;
      if (commit_now) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
         count_d   = count_q + 8'd1;
      end
      if (wr_strobe) begin
         if (int'(bus.spi_register_address) < NUM_TAPS) begin
            shadow_d[wr_idx] = bus.spi_register_value;
         end else if (bus.spi_register_address == ADDR_CTRL) begin
            if (bus.spi_register_value[CTRL_COMMIT_BIT] && !pending_q) pending_d = 1'b1;
            if (bus.spi_register_value[CTRL_CLR_ERR_BIT]) err_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_comb begin
      status = '0;
      status[STATUS_PENDING_BIT] = pending_q;
      status[STATUS_ERR_BIT]     = err_q;
      status[STATUS_COUNT_LSB +: 8] = count_q;

      rd_d = '0;
      if (int'(bus.spi_read_address) < NUM_TAPS) begin
         rd_d = shadow_q[rd_idx];
      end else if (bus.spi_read_address == ADDR_STATUS) begin
         rd_d = status;
      end else if ((bus.spi_read_address & 8'hE0) == ADDR_ACTIVE_BASE &&
                   int'(rd_idx) < NUM_TAPS) begin
         rd_d = active_q[rd_idx];
      end

      tap_d = '0;
      if (int'(bus.tap_index) < NUM_TAPS) tap_d = active_q[bus.tap_index];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         shadow_q  <= '{default: '0};
         active_q  <= '{default: '0};
         pending_q <= 1'b0;
         err_q     <= 1'b0;
         count_q   <= '0;
         rd_q      <= '0;
         tap_q     <= '0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         err_q     <= err_d;
         count_q   <= count_d;
         rd_q      <= rd_d;
         tap_q     <= tap_d;
      end
   end

   assign bus.spi_read_value = rd_q;
   assign bus.tap_coef       = tap_q;
   assign bus.commit_pending = pending_q;
   assign bus.err_addr       = err_q;
endmodule

// File: tb/tb_fir_coeff_bank.sv
// Self-checking bench for fir_coeff_bank: register-access vector table plus
// directed sequences for commit timing, counter wrap and mid-operation reset.
module tb_fir_coeff_bank;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   fir_coeff_bank_if #(.COEF_W(16)) bus ();

   fir_coeff_bank #(.NUM_TAPS(32), .COEF_W(16), .SYNC_STAGES(2)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0]  wa;
      logic [15:0] wv;
      logic [7:0]  ra;
      logic [15:0] er;
      logic        ee;
      logic        ep;
   } vec_t;

   vec_t        tbl [10];
   logic [15:0] rd_sb [$];
   logic [15:0] tap_sb [$];

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // spi_load held for one SCK period, SCK being 8 Clk periods.
   task automatic spi_write(input logic [7:0] a, input logic [15:0] v);
      bus.spi_register_address = a;
      bus.spi_register_value   = v;
      bus.spi_load = 1'b1;
      repeat (8) step();
      bus.spi_load = 1'b0;
      repeat (4) step();
   endtask

   task automatic tick();
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      step();
   endtask

   task automatic check_read(input string nm, input logic [7:0] a, input logic [15:0] e);
      bus.spi_read_address = a;
      rd_sb.push_back(e);
      step();
      chk(nm, bus.spi_read_value, rd_sb.pop_front());
   endtask

   task automatic check_tap(input string nm, input logic [4:0] idx, input logic [15:0] e);
      bus.tap_index = idx;
      tap_sb.push_back(e);
      step();
      chk(nm, bus.tap_coef, tap_sb.pop_front());
   endtask

   // Write whose strobe cycle coincides with a sample_tick.
   task automatic write_with_tick(input logic [7:0] a, input logic [15:0] v);
      bus.spi_register_address = a;
      bus.spi_register_value   = v;
      bus.spi_load = 1'b1;
      step();
      step();
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      repeat (5) step();
      bus.spi_load = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{8'h00, 16'hA5A5, 8'h00, 16'hA5A5, 1'b0, 1'b0};
      tbl[1] = '{8'h1F, 16'hFFFF, 8'h1F, 16'hFFFF, 1'b0, 1'b0};
      tbl[2] = '{8'h30, 16'hBEEF, 8'h10, 16'h0000, 1'b1, 1'b0};
      tbl[3] = '{8'h40, 16'h1111, 8'h21, 16'h0002, 1'b1, 1'b0};
      tbl[4] = '{8'h20, 16'h0002, 8'h21, 16'h0000, 1'b0, 1'b0};
      tbl[5] = '{8'h20, 16'h0000, 8'hA0, 16'h0000, 1'b0, 1'b0};
      tbl[6] = '{8'h20, 16'h0001, 8'h21, 16'h0001, 1'b0, 1'b1};
      tbl[7] = '{8'h20, 16'h0001, 8'h21, 16'h0001, 1'b0, 1'b1};
      tbl[8] = '{8'hFF, 16'h0000, 8'h05, 16'h1234, 1'b1, 1'b1};
      tbl[9] = '{8'h20, 16'h0002, 8'h85, 16'h0000, 1'b0, 1'b1};

      bus.spi_load = 1'b0;
      bus.spi_register_address = '0;
      bus.spi_register_value   = '0;
      bus.spi_read_address     = 8'h21;
      bus.sample_tick = 1'b0;
      bus.tap_index   = 5'd5;
      repeat (3) step();
      Reset = 1'b0;
      step();

      chk("rst_status", bus.spi_read_value, 16'h0000);
      chk("rst_tap", bus.tap_coef, 16'h0000);
      chk("rst_pending", {15'b0, bus.commit_pending}, 16'h0000);
      chk("rst_err", {15'b0, bus.err_addr}, 16'h0000);

      // Write latency: shadow updated on the third Clk edge, read-back one later.
      bus.spi_read_address = 8'h05;
      bus.spi_register_address = 8'h05;
      bus.spi_register_value   = 16'h1234;
      bus.spi_load = 1'b1;
      repeat (3) step();
      chk("wr_lat_early", bus.spi_read_value, 16'h0000);
      step();
      chk("wr_lat_done", bus.spi_read_value, 16'h1234);
      repeat (4) step();
      bus.spi_load = 1'b0;
      repeat (4) step();
      check_tap("tap5_precommit", 5'd5, 16'h0000);
      check_read("active5_precommit", 8'h85, 16'h0000);

      for (int i = 0; i < 10; i++) begin
         spi_write(tbl[i].wa, tbl[i].wv);
         check_read($sformatf("vec%0d_rd", i), tbl[i].ra, tbl[i].er);
         chk($sformatf("vec%0d_err", i), {15'b0, bus.err_addr}, {15'b0, tbl[i].ee});
         chk($sformatf("vec%0d_pend", i), {15'b0, bus.commit_pending}, {15'b0, tbl[i].ep});
      end

      // Commit on a tick; tap output switches whole, one cycle after the copy.
      bus.tap_index = 5'd5;
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      chk("commit_tap_old", bus.tap_coef, 16'h0000);
      chk("commit_pend_clr", {15'b0, bus.commit_pending}, 16'h0000);
      step();
      chk("commit_tap_new", bus.tap_coef, 16'h1234);
      check_read("commit_active5", 8'h85, 16'h1234);
      check_read("commit_status", 8'h21, 16'h0100);
      check_tap("tap31", 5'd31, 16'hFFFF);

      // Shadow write in the copy cycle: active gets the pre-write value.
      spi_write(8'h20, 16'h0001);
      write_with_tick(8'h00, 16'h5555);
      check_read("race_active0", 8'h80, 16'hA5A5);
      check_read("race_shadow0", 8'h00, 16'h5555);
      check_read("race_status", 8'h21, 16'h0200);

      // Commit request landing with a tick waits for the next tick.
      write_with_tick(8'h20, 16'h0001);
      check_read("sametick_status", 8'h21, 16'h0201);
      check_read("sametick_active0", 8'h80, 16'hA5A5);
      tick();
      check_read("nexttick_status", 8'h21, 16'h0300);
      check_read("nexttick_active0", 8'h80, 16'h5555);

      for (int n = 0; n < 252; n++) begin
         spi_write(8'h20, 16'h0001);
         tick();
      end
      check_read("count_255", 8'h21, 16'hFF00);
      spi_write(8'h20, 16'h0001);
      tick();
      check_read("count_wrap", 8'h21, 16'h0000);

      // Reset with a commit pending and a write strobe inside the synchroniser.
      spi_write(8'h20, 16'h0001);
      chk("prereset_pend", {15'b0, bus.commit_pending}, 16'h0001);
      bus.spi_register_address = 8'h07;
      bus.spi_register_value   = 16'h7777;
      bus.spi_load = 1'b1;
      step();
      Reset = 1'b1;
      bus.spi_load = 1'b0;
      repeat (3) step();
      Reset = 1'b0;
      repeat (6) step();
      tick();
      tick();
      chk("postreset_pend", {15'b0, bus.commit_pending}, 16'h0000);
      chk("postreset_err", {15'b0, bus.err_addr}, 16'h0000);
      check_read("postreset_status", 8'h21, 16'h0000);
      check_read("postreset_shadow7", 8'h07, 16'h0000);
      check_read("postreset_shadow0", 8'h00, 16'h0000);
      check_read("postreset_active0", 8'h80, 16'h0000);
      check_tap("postreset_tap5", 5'd5, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
